// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans a 4x4 hex keypad, debounces every key and
// publishes a 16-bit "key k held" bus plus a one-cycle press event.
// Optional build macro KEYPAD_GHOST_MASK_EN: when defined, frames that contain
// a pressed rectangle (possible ghost key) are dropped at commit.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 64,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  output logic [15:0] keypad_matrix,
  output logic        key_pulse,
  output logic [3:0]  key_code
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 2);
  localparam logic [3:0]    DB_LAST     = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic {DRIVE, SAMPLE} state_t;

  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic [1:0]       col_q, col_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      db_q, db_d;
  logic [15:0][3:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic [3:0]       code_q, code_d;
  logic             commit;
  logic             reject;
  logic [15:0]      rise;

`ifdef KEYPAD_GHOST_MASK_EN
  logic [3:0][3:0]  row_bits;
`endif

  // Physical (row, col) position to hex key index.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hC;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hD;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'h0;  4'hE: k = 4'hB;  default: k = 4'hF;
    endcase
    return k;
  endfunction

  // Idle (all columns released) until the first cycle out of reset.
  assign col_out       = run_q ? ~(4'b0001 << col_q) : 4'b1111;
  assign keypad_matrix = db_q;
  assign key_pulse     = pulse_q;
  assign key_code      = code_q;

  // Scan FSM: settle on a column, then capture its rows into the raw frame.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    col_d    = col_q;
    raw_d    = raw_q;
    run_d    = 1'b1;
    sync1_d  = row_in;
    sync2_d  = sync1_q;
    commit   = 1'b0;
    if (run_q) begin
      case (state_q)
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = SAMPLE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        default: begin
          for (int r = 0; r < 4; r++) raw_d[key_at(2'(r), col_q)] = ~sync2_q[r];
          col_d   = col_q + 1'b1;
          state_d = DRIVE;
          commit  = (col_q == 2'd3);
        end
      endcase
    end
  end

  // Frame commit: per-key debounce counters, toggles and the press event.
  always_comb begin
    db_d    = db_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    code_d  = code_q;
    reject  = 1'b0;
    rise    = '0;
`ifdef KEYPAD_GHOST_MASK_EN
    row_bits = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) row_bits[r][c] = raw_d[key_at(2'(r), 2'(c))];
    for (int a = 0; a < 3; a++)
      for (int b = a + 1; b < 4; b++)
        if ($countones(row_bits[a] & row_bits[b]) >= 2) reject = 1'b1;
`endif
    if (commit && !reject) begin
      for (int k = 0; k < 16; k++) begin
        if (raw_d[k] == db_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == DB_LAST) begin
          db_d[k]  = ~db_q[k];
          cnt_d[k] = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
      rise = db_d & ~db_q;
      if (|rise) begin
        pulse_d = 1'b1;
        // Descending walk so the lowest rising index is the one kept.
        for (int k = 15; k >= 0; k--) if (rise[k]) code_d = 4'(k);
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= DRIVE;
      run_q    <= 1'b0;
      col_q    <= '0;
      settle_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      raw_q    <= '0;
      db_q     <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      raw_q    <= raw_d;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      code_q   <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad (including
// ghost-key formation) driving row_in from col_out.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  col_out, row_in, key_code;
  logic [15:0] keypad_matrix;
  logic        key_pulse;

  logic [15:0] pressed = '0;
  logic [15:0] eff;
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          pulse_cnt = 0;
  logic [3:0]  last_code = '0;

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk(clk), .reset(reset), .col_out(col_out), .row_in(row_in),
    .keypad_matrix(keypad_matrix), .key_pulse(key_pulse), .key_code(key_code)
  );

  function automatic int key_of(int r, int c);
    logic [15:0] row;
    case (r)
      0: row = 16'h123C;
      1: row = 16'h456D;
      2: row = 16'h789E;
      default: row = 16'hA0BF;
    endcase
    return int'(row[(3-c)*4 +: 4]);
  endfunction

  // Keypad model: three corners of a rectangle held make the fourth conduct.
  always_comb begin
    eff = pressed;
    for (int r1 = 0; r1 < 3; r1++)
      for (int r2 = r1 + 1; r2 < 4; r2++)
        for (int c1 = 0; c1 < 3; c1++)
          for (int c2 = c1 + 1; c2 < 4; c2++)
            if (int'(pressed[key_of(r1,c1)]) + int'(pressed[key_of(r1,c2)]) +
                int'(pressed[key_of(r2,c1)]) + int'(pressed[key_of(r2,c2)]) >= 3) begin
              eff[key_of(r1,c1)] = 1'b1; eff[key_of(r1,c2)] = 1'b1;
              eff[key_of(r2,c1)] = 1'b1; eff[key_of(r2,c2)] = 1'b1;
            end
  end

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && eff[key_of(r,c)]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_pulse === 1'b1) begin
      pulse_cnt++;
      last_code = key_code;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_matrix(input string tag, input logic [15:0] exp, input int budget,
                             output int cyc, output logic pulse_at);
    cyc = 0;
    while (keypad_matrix !== exp && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    pulse_at = key_pulse;
    chk(tag, keypad_matrix, exp);
  endtask

  // Stop on the first cycle of column 0 (start of a new frame).
  task automatic align();
    int n = 0;
    while (col_out !== 4'b0111 && n < 600) begin @(negedge clk); n++; end
    while (col_out !== 4'b1110 && n < 1200) begin @(negedge clk); n++; end
    chk("frame_align", {15'b0, n < 1200}, 16'd1);
  endtask

  initial begin
    int cyc, p0;
    logic pa;
    logic [3:0] e;
    logic [15:0] acc;

    // Reset held for 5 cycles
    tick(5);
    chk("rst_col", {12'b0, col_out}, 16'h000F);
    chk("rst_matrix", keypad_matrix, 16'h0000);
    chk("rst_pulse", {15'b0, key_pulse}, 16'h0000);
    chk("rst_code", {12'b0, key_code}, 16'h0000);

    // Column walk after release: 64 clocks per column, wraps at 256
    reset = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      tick(1);
      if (i inside {1, 64, 65, 129, 193, 256, 257}) begin
        e = ~(4'b0001 << (((i - 1) / 64) % 4));
        chk($sformatf("col_step_%0d", i), {12'b0, col_out}, {12'b0, e});
      end
    end

    // Clean press of key 6 (row1, col2)
    pressed[6] = 1'b1;
    wait_matrix("press6", 16'h0040, 1300, cyc, pa);
    chk("press6_lat_max", {15'b0, cyc <= 1280}, 16'd1);
    chk("press6_lat_min", {15'b0, cyc >= 768}, 16'd1);
    chk("press6_pulse_with_matrix", {15'b0, pa}, 16'd1);
    tick(1);
    chk("press6_pulse_one_cycle", {15'b0, key_pulse}, 16'd0);
    tick(2);
    chk("press6_pulse_count", 16'(pulse_cnt), 16'd1);
    chk("press6_code", {12'b0, key_code}, 16'h0006);
    chk("press6_mon_code", {12'b0, last_code}, 16'h0006);

    // Release: back to zero, no pulse, code held
    p0 = pulse_cnt;
    pressed = '0;
    wait_matrix("release6", 16'h0000, 1300, cyc, pa);
    tick(3);
    chk("release6_no_pulse", 16'(pulse_cnt), 16'(p0));
    chk("release6_code_hold", {12'b0, key_code}, 16'h0006);

    // Bounce: key A toggled every frame for 12 frames
    p0 = pulse_cnt;
    acc = '0;
    for (int f = 0; f < 12; f++) begin
      pressed[10] = (f % 2 == 0);
      for (int j = 0; j < 256; j++) begin
        tick(1);
        acc |= keypad_matrix;
      end
    end
    pressed = '0;
    tick(2);
    chk("bounce_matrix", acc, 16'h0000);
    chk("bounce_no_pulse", 16'(pulse_cnt), 16'(p0));

    // Simultaneous press of keys 0 and F in one frame
    align();
    p0 = pulse_cnt;
    pressed = 16'h8001;
    wait_matrix("simul_matrix", 16'h8001, 1300, cyc, pa);
    chk("simul_pulse_with_matrix", {15'b0, pa}, 16'd1);
    tick(3);
    chk("simul_single_pulse", 16'(pulse_cnt - p0), 16'd1);
    chk("simul_code", {12'b0, key_code}, 16'h0000);
    pressed = '0;
    wait_matrix("simul_release", 16'h0000, 1300, cyc, pa);

    // Reset mid-debounce with key 5 held throughout
    align();
    pressed[5] = 1'b1;
    tick(512);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_col", {12'b0, col_out}, 16'h000F);
    chk("mid_rst_matrix", keypad_matrix, 16'h0000);
    chk("mid_rst_pulse", {15'b0, key_pulse}, 16'd0);
    reset = 1'b1;
    p0 = pulse_cnt;
    tick(1024);
    chk("mid_rst_not_early", keypad_matrix, 16'h0000);
    chk("mid_rst_no_stale_pulse", 16'(pulse_cnt), 16'(p0));
    tick(1);
    chk("mid_rst_rise", keypad_matrix, 16'h0020);
    chk("mid_rst_pulse_now", {15'b0, key_pulse}, 16'd1);
    tick(2);
    chk("mid_rst_code", {12'b0, key_code}, 16'h0005);
    pressed = '0;
    wait_matrix("mid_rst_release", 16'h0000, 1300, cyc, pa);

    // Ghost: 1, 2 and 4 held, model adds 5
    p0 = pulse_cnt;
    pressed = 16'h0016;
    tick(1536);
`ifdef KEYPAD_GHOST_MASK_EN
    chk("ghost_matrix", keypad_matrix, 16'h0000);
    chk("ghost_pulse", {15'b0, pulse_cnt != p0}, 16'd0);
`else
    chk("ghost_matrix", keypad_matrix, 16'h0036);
    chk("ghost_pulse", {15'b0, pulse_cnt != p0}, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
